// File: rtl/ex_mem_latch.sv
// ex_mem_latch -- EX/MEM pipeline register feeding the memory-access stage.
//
// Holds the instruction, PC, ALU result/address, destination register,
// store data and access type that the MEM stage consumes. It supports:
//   * upstream stall (contents held),
//   * bubble-inserting flush (NOP_INSTR / RWE_IDLE, other fields zero),
//   * a RAM2 hold: a read or write whose address has bit 15 clear targets
//     RAM2, which is shared with instruction fetch. Such an access is kept
//     stable for RAM2_HOLD_CYCLES cycles and the upstream pipeline is told
//     to freeze in the meantime.
//
// Ports:
//   memi_clk                 in   system clock, rising edge
//   memi_rst                 in   asynchronous reset, active low
//   exi_instr/pc/data        in   instruction, PC, ALU result / address from EX
//   exi_wreg_addr            in   destination register
//   exi_write_to_mem_data    in   store data
//   exi_rwe                  in   access type
//   stall_in                 in   hazard-unit stall, hold contents
//   flush_in                 in   replace next load with a bubble
//   exmo_*                   out  registered copies of the exi_* fields
//   exmo_stall_req           out  high while a RAM2 hold is active
//   exmo_hold_cnt            out  remaining hold cycles (debug)
//
// RAM2_HOLD_CYCLES must lie in 1..4 (hold counter is 2 bits wide).

module ex_mem_latch #(
  parameter logic [15:0] NOP_INSTR        = 16'h0800,
  parameter logic [1:0]  RWE_IDLE         = 2'b00,
  parameter logic [1:0]  RWE_RD           = 2'b01,
  parameter logic [1:0]  RWE_WR           = 2'b10,
  parameter int unsigned RAM2_HOLD_CYCLES = 3
) (
  input  logic        memi_clk,
  input  logic        memi_rst,
  input  logic [15:0] exi_instr,
  input  logic [15:0] exi_pc,
  input  logic [15:0] exi_data,
  input  logic [3:0]  exi_wreg_addr,
  input  logic [15:0] exi_write_to_mem_data,
  input  logic [1:0]  exi_rwe,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [15:0] exmo_instr,
  output logic [15:0] exmo_pc,
  output logic [15:0] exmo_data,
  output logic [3:0]  exmo_wreg_addr,
  output logic [15:0] exmo_write_to_mem_data,
  output logic [1:0]  exmo_rwe,
  output logic        exmo_stall_req,
  output logic [1:0]  exmo_hold_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] HOLD_INIT = 2'(RAM2_HOLD_CYCLES - 1);
  localparam logic       HOLD_EN   = (RAM2_HOLD_CYCLES > 1);

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  wreg_q, wreg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  rwe_q, rwe_d;
  logic [0:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pflush_q, pflush_d;

  // A memory read or write in the lower half of the address space is RAM2.
  function automatic logic is_ram2(input logic [1:0] rwe, input logic [15:0] addr);
    return ((rwe == RWE_RD) || (rwe == RWE_WR)) && !addr[15];
  endfunction

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    data_d   = data_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    rwe_d    = rwe_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pflush_d = pflush_q;

    if (state_q == ST_HOLD) begin
      // Register frozen; a flush arriving now is remembered and turned into
      // exactly one bubble on the first cycle back in IDLE.
      if (flush_in) begin
        pflush_d = 1'b1;
      end
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (flush_in || pflush_q) begin
        instr_d  = NOP_INSTR;
        pc_d     = '0;
        data_d   = '0;
        wreg_d   = '0;
        wdata_d  = '0;
        rwe_d    = RWE_IDLE;
        pflush_d = 1'b0;
      end else if (!stall_in) begin
        instr_d = exi_instr;
        pc_d    = exi_pc;
        data_d  = exi_data;
        wreg_d  = exi_wreg_addr;
        wdata_d = exi_write_to_mem_data;
        rwe_d   = exi_rwe;
        if (HOLD_EN && is_ram2(exi_rwe, exi_data)) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
    end
  end

  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      data_q   <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      rwe_q    <= RWE_IDLE;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pflush_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      data_q   <= data_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      rwe_q    <= rwe_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pflush_q <= pflush_d;
    end
  end

  assign exmo_instr             = instr_q;
  assign exmo_pc                = pc_q;
  assign exmo_data              = data_q;
  assign exmo_wreg_addr         = wreg_q;
  assign exmo_write_to_mem_data = wdata_q;
  assign exmo_rwe               = rwe_q;
  assign exmo_stall_req         = (state_q == ST_HOLD);
  assign exmo_hold_cnt          = cnt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: a table of single-cycle vectors in
// IDLE plus hand-written sequences for the RAM2 hold, flush during hold,
// long stall, back-to-back RAM2 accesses and asynchronous reset mid-hold.

module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] exi_instr, exi_pc, exi_data, exi_wdata;
  logic [3:0]  exi_wreg;
  logic [1:0]  exi_rwe;
  logic        stall_in, flush_in;
  logic [15:0] o_instr, o_pc, o_data, o_wdata;
  logic [3:0]  o_wreg;
  logic [1:0]  o_rwe;
  logic        o_stall;
  logic [1:0]  o_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(
    .NOP_INSTR        (16'h0800),
    .RWE_IDLE         (2'b00),
    .RWE_RD           (2'b01),
    .RWE_WR           (2'b10),
    .RAM2_HOLD_CYCLES (3)
  ) dut (
    .memi_clk               (clk),
    .memi_rst               (rst),
    .exi_instr              (exi_instr),
    .exi_pc                 (exi_pc),
    .exi_data               (exi_data),
    .exi_wreg_addr          (exi_wreg),
    .exi_write_to_mem_data  (exi_wdata),
    .exi_rwe                (exi_rwe),
    .stall_in               (stall_in),
    .flush_in               (flush_in),
    .exmo_instr             (o_instr),
    .exmo_pc                (o_pc),
    .exmo_data              (o_data),
    .exmo_wreg_addr         (o_wreg),
    .exmo_write_to_mem_data (o_wdata),
    .exmo_rwe               (o_rwe),
    .exmo_stall_req         (o_stall),
    .exmo_hold_cnt          (o_cnt)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] data;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic [1:0]  rwe;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_data;
    logic [3:0]  e_wreg;
    logic [15:0] e_wdata;
    logic [1:0]  e_rwe;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name,
                         input logic [15:0] e_instr, input logic [15:0] e_pc,
                         input logic [15:0] e_data, input logic [3:0] e_wreg,
                         input logic [15:0] e_wdata, input logic [1:0] e_rwe,
                         input logic e_stall, input logic [1:0] e_cnt);
    chk({name, ".instr"}, o_instr, e_instr);
    chk({name, ".pc"},    o_pc,    e_pc);
    chk({name, ".data"},  o_data,  e_data);
    chk({name, ".wreg"},  {12'h0, o_wreg}, {12'h0, e_wreg});
    chk({name, ".wdata"}, o_wdata, e_wdata);
    chk({name, ".rwe"},   {14'h0, o_rwe},  {14'h0, e_rwe});
    chk({name, ".stall"}, {15'h0, o_stall}, {15'h0, e_stall});
    chk({name, ".cnt"},   {14'h0, o_cnt},  {14'h0, e_cnt});
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] pc,
                       input logic [15:0] data, input logic [3:0] wreg,
                       input logic [15:0] wdata, input logic [1:0] rwe);
    exi_instr = instr;
    exi_pc    = pc;
    exi_data  = data;
    exi_wreg  = wreg;
    exi_wdata = wdata;
    exi_rwe   = rwe;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'h9A01, 16'h0010, 16'h8004, 4'h3, 16'h0000, 2'b01,
               16'h9A01, 16'h0010, 16'h8004, 4'h3, 16'h0000, 2'b01};
    tbl[1] = '{1'b0, 1'b0, 16'h1111, 16'h0011, 16'hBF00, 4'h5, 16'h00AA, 2'b01,
               16'h1111, 16'h0011, 16'hBF00, 4'h5, 16'h00AA, 2'b01};
    tbl[2] = '{1'b1, 1'b0, 16'h2222, 16'h0012, 16'h0100, 4'h6, 16'h0001, 2'b10,
               16'h1111, 16'h0011, 16'hBF00, 4'h5, 16'h00AA, 2'b01};
    tbl[3] = '{1'b1, 1'b1, 16'h3333, 16'h0013, 16'h0200, 4'h7, 16'h0002, 2'b01,
               16'h0800, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'b00};
    tbl[4] = '{1'b0, 1'b0, 16'h4321, 16'h0020, 16'h7FFF, 4'h7, 16'h5555, 2'b00,
               16'h4321, 16'h0020, 16'h7FFF, 4'h7, 16'h5555, 2'b00};
    tbl[5] = '{1'b0, 1'b0, 16'h5A5A, 16'h0021, 16'h0004, 4'h2, 16'h0F0F, 2'b11,
               16'h5A5A, 16'h0021, 16'h0004, 4'h2, 16'h0F0F, 2'b11};
    tbl[6] = '{1'b0, 1'b1, 16'h6666, 16'h0022, 16'h8888, 4'h4, 16'h0003, 2'b01,
               16'h0800, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'b00};
    tbl[7] = '{1'b0, 1'b0, 16'h6000, 16'h0030, 16'h8000, 4'h1, 16'hBEEF, 2'b10,
               16'h6000, 16'h0030, 16'h8000, 4'h1, 16'hBEEF, 2'b10};

    // Reset held across several edges with random inputs.
    rst      = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
          16'($urandom), 2'($urandom));
    repeat (3) step();
    chk_all("reset", 16'h0800, 16'h0, 16'h0, 4'h0, 16'h0, 2'b00, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single-cycle vectors in IDLE, applied back to back.
    for (int i = 0; i < 8; i++) begin
      stall_in = tbl[i].stall;
      flush_in = tbl[i].flush;
      drive(tbl[i].instr, tbl[i].pc, tbl[i].data, tbl[i].wreg, tbl[i].wdata, tbl[i].rwe);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_data,
              tbl[i].e_wreg, tbl[i].e_wdata, tbl[i].e_rwe, 1'b0, 2'd0);
    end
    stall_in = 1'b0;
    flush_in = 1'b0;

    // RAM2 write held for three cycles, next input latched on the third edge.
    drive(16'h7000, 16'h0040, 16'h4000, 4'h0, 16'h1234, 2'b10);
    step();
    chk_all("wr2_c0", 16'h7000, 16'h0040, 16'h4000, 4'h0, 16'h1234, 2'b10, 1'b1, 2'd2);
    drive(16'h8888, 16'h0041, 16'h8100, 4'h9, 16'h0000, 2'b01);
    step();
    chk_all("wr2_c1", 16'h7000, 16'h0040, 16'h4000, 4'h0, 16'h1234, 2'b10, 1'b1, 2'd1);
    step();
    chk_all("wr2_c2", 16'h7000, 16'h0040, 16'h4000, 4'h0, 16'h1234, 2'b10, 1'b0, 2'd0);
    step();
    chk_all("wr2_next", 16'h8888, 16'h0041, 16'h8100, 4'h9, 16'h0000, 2'b01, 1'b0, 2'd0);

    // Flush during hold becomes a single bubble after release.
    drive(16'h9B02, 16'h0050, 16'h0010, 4'h4, 16'h0000, 2'b01);
    step();
    chk_all("fh_c0", 16'h9B02, 16'h0050, 16'h0010, 4'h4, 16'h0000, 2'b01, 1'b1, 2'd2);
    flush_in = 1'b1;
    drive(16'h1357, 16'h0051, 16'h8200, 4'h6, 16'h0000, 2'b01);
    step();
    chk_all("fh_c1", 16'h9B02, 16'h0050, 16'h0010, 4'h4, 16'h0000, 2'b01, 1'b1, 2'd1);
    flush_in = 1'b0;
    step();
    chk_all("fh_c2", 16'h9B02, 16'h0050, 16'h0010, 4'h4, 16'h0000, 2'b01, 1'b0, 2'd0);
    step();
    chk_all("fh_bubble", 16'h0800, 16'h0, 16'h0, 4'h0, 16'h0, 2'b00, 1'b0, 2'd0);
    step();
    chk_all("fh_load", 16'h1357, 16'h0051, 16'h8200, 4'h6, 16'h0000, 2'b01, 1'b0, 2'd0);

    // Stall alone holds contents across four edges.
    stall_in = 1'b1;
    drive(16'hFFFF, 16'h00FF, 16'h9999, 4'hF, 16'hFFFF, 2'b10);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 16'h1357, 16'h0051, 16'h8200, 4'h6, 16'h0000,
              2'b01, 1'b0, 2'd0);
    end
    stall_in = 1'b0;

    // Stall ignored in hold; back-to-back RAM2 accesses with no extra gap.
    drive(16'h0C0C, 16'h0060, 16'h0000, 4'h8, 16'h00FF, 2'b01);
    step();
    chk_all("b2b_a0", 16'h0C0C, 16'h0060, 16'h0000, 4'h8, 16'h00FF, 2'b01, 1'b1, 2'd2);
    stall_in = 1'b1;
    drive(16'h0D0D, 16'h0061, 16'h7FFE, 4'h9, 16'h0000, 2'b10);
    step();
    chk_all("b2b_a1", 16'h0C0C, 16'h0060, 16'h0000, 4'h8, 16'h00FF, 2'b01, 1'b1, 2'd1);
    step();
    chk_all("b2b_a2", 16'h0C0C, 16'h0060, 16'h0000, 4'h8, 16'h00FF, 2'b01, 1'b0, 2'd0);
    stall_in = 1'b0;
    step();
    chk_all("b2b_b0", 16'h0D0D, 16'h0061, 16'h7FFE, 4'h9, 16'h0000, 2'b10, 1'b1, 2'd2);
    step();
    chk_all("b2b_b1", 16'h0D0D, 16'h0061, 16'h7FFE, 4'h9, 16'h0000, 2'b10, 1'b1, 2'd1);
    step();
    chk_all("b2b_b2", 16'h0D0D, 16'h0061, 16'h7FFE, 4'h9, 16'h0000, 2'b10, 1'b0, 2'd0);

    // Asynchronous reset in the middle of a hold.
    drive(16'h0E0E, 16'h0070, 16'h1000, 4'hA, 16'hCAFE, 2'b10);
    step();
    chk_all("ar_hold", 16'h0E0E, 16'h0070, 16'h1000, 4'hA, 16'hCAFE, 2'b10, 1'b1, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_all("ar_reset", 16'h0800, 16'h0, 16'h0, 4'h0, 16'h0, 2'b00, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(16'h2468, 16'h0080, 16'hC000, 4'hB, 16'h1357, 2'b01);
    step();
    chk_all("ar_after", 16'h2468, 16'h0080, 16'hC000, 4'hB, 16'h1357, 2'b01, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
